// File: rtl/instr_loader_pkg.sv
// ============================================================================
// Module   : instr_loader_pkg
// Purpose  : Shared state encoding and word-geometry constants for the loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int c_BYTE_IDX_W   = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/instr_word_packer.sv
// ============================================================================
// Module   : instr_word_packer
// Purpose  : Packs MSB-first bytes into 32-bit words and flags the last byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_word_packer
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  localparam logic [c_BYTE_IDX_W-1:0] c_LAST_IDX = c_BYTE_IDX_W'(BYTES_PER_WORD - 1);

  logic [23:0]             r_shift;
  logic [c_BYTE_IDX_W-1:0] r_idx;

  // The completed word includes the byte arriving this cycle, so the top
  // level can capture it on the same edge that accepts the final byte.
  assign word_done = byte_en && (r_idx == c_LAST_IDX);
  assign word      = {r_shift, byte_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (clear) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (byte_en) begin
      r_shift <= {r_shift[15:0], byte_in};
      r_idx   <= r_idx + c_BYTE_IDX_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_loader.sv
// ============================================================================
// Module   : instr_loader
// Purpose  : Loads a checksummed byte-stream program into instruction RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_wa,
  output logic [31:0]       mem_wd,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_written
);

  state_t r_state;
  state_t w_next;

  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_wa;
  logic [31:0]       r_mem_wd;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_error;
  logic [ADDR_W-1:0] r_words;
  logic [7:0]        r_count;
  logic [7:0]        r_chk;

  logic        w_accept;
  logic        w_start_ok;
  logic        w_data_en;
  logic        w_word_done;
  logic        w_last_word;
  logic [31:0] w_word;

  assign byte_ready  = (r_state == ST_COUNT) || (r_state == ST_DATA) || (r_state == ST_CHECK);
  assign w_accept    = byte_valid && byte_ready;
  assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                 (r_state == ST_ERROR));
  assign w_data_en   = w_accept && (r_state == ST_DATA);
  assign w_last_word = (r_words + ADDR_W'(1)) == ADDR_W'(r_count);

  instr_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (w_start_ok),
    .byte_en   (w_data_en),
    .byte_in   (byte_in),
    .word      (w_word),
    .word_done (w_word_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) w_next = ST_COUNT;
      end
      ST_COUNT: begin
        if (w_accept) w_next = (byte_in == 8'd0) ? ST_CHECK : ST_DATA;
      end
      ST_DATA: begin
        if (w_word_done && w_last_word) w_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_accept) w_next = (byte_in == r_chk) ? ST_DONE : ST_ERROR;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Start and byte acceptance are mutually exclusive by state, so their
  // register updates never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_we   <= 1'b0;
      r_mem_wa   <= '0;
      r_mem_wd   <= '0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_words    <= '0;
      r_count    <= '0;
      r_chk      <= '0;
    end else begin
      r_mem_we <= 1'b0;

      if (w_start_ok) begin
        r_words    <= '0;
        r_chk      <= '0;
        r_cpu_hold <= 1'b1;
        r_done     <= 1'b0;
        r_error    <= 1'b0;
      end

      if (w_accept) begin
        case (r_state)
          ST_COUNT: begin
            r_count <= byte_in;
            r_chk   <= byte_in;
          end
          ST_DATA: r_chk <= r_chk ^ byte_in;
          ST_CHECK: begin
            if (byte_in == r_chk) begin
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_error <= 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (w_word_done) begin
        r_mem_we <= 1'b1;
        r_mem_wa <= r_words;
        r_mem_wd <= w_word;
        r_words  <= r_words + ADDR_W'(1);
      end
    end
  end

  assign mem_we        = r_mem_we;
  assign mem_wa        = r_mem_wa;
  assign mem_wd        = r_mem_wd;
  assign cpu_hold      = r_cpu_hold;
  assign done          = r_done;
  assign error         = r_error;
  assign words_written = r_words;

endmodule

`default_nettype wire

// File: tb/tb_instr_loader.sv
// ============================================================================
// Module   : tb_instr_loader
// Purpose  : Directed self-checking bench for instr_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        byte_in = 8'h00;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [31:0]       mem_wd;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] words_written;

  int checks = 0;
  int failures = 0;

  logic [7:0]        stream [0:9];
  logic [ADDR_W-1:0] wr_addr [$];
  logic [31:0]       wr_data [$];
  logic [39:0]       got0;
  logic [39:0]       got1;

  localparam logic [39:0] c_EXP_W0 = {8'h00, 32'h2001_0003};
  localparam logic [39:0] c_EXP_W1 = {8'h01, 32'h2002_0009};

  instr_loader #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .mem_we        (mem_we),
    .mem_wa        (mem_wa),
    .mem_wd        (mem_wd),
    .cpu_hold      (cpu_hold),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_wa);
      wr_data.push_back(mem_wd);
    end
  end

  task automatic set_normal(input logic [7:0] last);
    stream[0] = 8'h02; stream[1] = 8'h20; stream[2] = 8'h01; stream[3] = 8'h00;
    stream[4] = 8'h03; stream[5] = 8'h20; stream[6] = 8'h02; stream[7] = 8'h00;
    stream[8] = 8'h09; stream[9] = last;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic grab_writes();
    got0 = (wr_addr.size() > 0) ? {wr_addr[0], wr_data[0]} : 40'hFF_FFFF_FFFF;
    got1 = (wr_addr.size() > 1) ? {wr_addr[1], wr_data[1]} : 40'hFF_FFFF_FFFF;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Holds the byte until the loader reports ready; entered and left at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    byte_valid = 1'b1;
    byte_in    = b;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (byte_ready === 1'b1) got = 1'b1;
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL byte_accept_timeout byte=%02h ready never seen in 50 cycles", b);
    end
  endtask

  task automatic send_stream(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      send_byte(stream[i]);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({cpu_hold, byte_ready, mem_we, done, error} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=10000", {cpu_hold, byte_ready, mem_we, done, error});
    end
    checks++;
    if ({words_written, mem_wa, mem_wd} !== 48'h0) begin
      failures++;
      $display("FAIL reset_regs got=%h exp=0", {words_written, mem_wa, mem_wd});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    byte_valid = 1'b1;
    byte_in    = 8'h55;
    repeat (2) @(posedge clk); #1;
    byte_valid = 1'b0;
    checks++;
    if ({byte_ready, cpu_hold, 32'(wr_addr.size())} !== {1'b0, 1'b1, 32'd0}) begin
      failures++;
      $display("FAIL idle_byte_ignored ready=%b hold=%b writes=%0d exp ready=0 hold=1 writes=0",
               byte_ready, cpu_hold, wr_addr.size());
    end
    // start and byte_valid together: only start acts, loader moves to COUNT.
    start      = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'h07;
    @(posedge clk); #1;
    start      = 1'b0;
    byte_valid = 1'b0;
    checks++;
    if (byte_ready !== 1'b1) begin
      failures++;
      $display("FAIL start_enters_count ready=%b exp=1", byte_ready);
    end
  endtask

  task automatic test_back_to_back();
    set_normal(8'h0B);
    clear_log();
    pulse_start();
    send_stream(10, 0);
    repeat (2) @(posedge clk); #1;
    grab_writes();
    checks++;
    if (wr_addr.size() != 2) begin
      failures++;
      $display("FAIL b2b_write_count got=%0d exp=2", wr_addr.size());
    end
    checks++;
    if (got0 !== c_EXP_W0 || got1 !== c_EXP_W1) begin
      failures++;
      $display("FAIL b2b_words got=%h,%h exp=%h,%h", got0, got1, c_EXP_W0, c_EXP_W1);
    end
    checks++;
    if ({done, error, cpu_hold, byte_ready, words_written} !== {4'b1000, 8'd2}) begin
      failures++;
      $display("FAIL b2b_final got=%b/%0d exp=1000/2", {done, error, cpu_hold, byte_ready},
               words_written);
    end
    // Bytes offered in DONE must be ignored.
    byte_valid = 1'b1;
    byte_in    = 8'hA5;
    repeat (3) @(posedge clk); #1;
    byte_valid = 1'b0;
    checks++;
    if ({done, byte_ready, words_written, 32'(wr_addr.size())} !== {1'b1, 1'b0, 8'd2, 32'd2}) begin
      failures++;
      $display("FAIL done_byte_ignored done=%b ready=%b ww=%0d writes=%0d exp 1 0 2 2",
               done, byte_ready, words_written, wr_addr.size());
    end
  endtask

  task automatic test_stalled();
    set_normal(8'h0B);
    clear_log();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      send_byte(stream[i]);
      if (i == 6) start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;
    end
    grab_writes();
    checks++;
    if (wr_addr.size() != 2) begin
      failures++;
      $display("FAIL stall_write_count got=%0d exp=2", wr_addr.size());
    end
    checks++;
    if (got0 !== c_EXP_W0 || got1 !== c_EXP_W1) begin
      failures++;
      $display("FAIL stall_words got=%h,%h exp=%h,%h", got0, got1, c_EXP_W0, c_EXP_W1);
    end
    checks++;
    if ({done, error, cpu_hold, byte_ready, words_written} !== {4'b1000, 8'd2}) begin
      failures++;
      $display("FAIL stall_final got=%b/%0d exp=1000/2", {done, error, cpu_hold, byte_ready},
               words_written);
    end
  endtask

  task automatic test_bad_checksum();
    set_normal(8'h0C);
    clear_log();
    pulse_start();
    send_stream(10, 0);
    repeat (2) @(posedge clk); #1;
    grab_writes();
    checks++;
    if (wr_addr.size() != 2 || got0 !== c_EXP_W0 || got1 !== c_EXP_W1) begin
      failures++;
      $display("FAIL badck_words n=%0d got=%h,%h exp=2 %h,%h", wr_addr.size(), got0, got1,
               c_EXP_W0, c_EXP_W1);
    end
    checks++;
    if ({done, error, cpu_hold, byte_ready} !== 4'b0110) begin
      failures++;
      $display("FAIL badck_flags got=%b exp=0110", {done, error, cpu_hold, byte_ready});
    end
    clear_log();
    pulse_start();
    checks++;
    if ({error, done, cpu_hold, byte_ready, words_written} !== {4'b0011, 8'd0}) begin
      failures++;
      $display("FAIL restart_clear got=%b/%0d exp=0011/0", {error, done, cpu_hold, byte_ready},
               words_written);
    end
    stream[9] = 8'h0B;
    send_stream(10, 0);
    repeat (2) @(posedge clk); #1;
    grab_writes();
    checks++;
    if ({done, error, cpu_hold, words_written, 32'(wr_addr.size())} !== {3'b100, 8'd2, 32'd2}
        || got1 !== c_EXP_W1) begin
      failures++;
      $display("FAIL reload_done got=%b ww=%0d n=%0d w1=%h exp=100 2 2 %h",
               {done, error, cpu_hold}, words_written, wr_addr.size(), got1, c_EXP_W1);
    end
  endtask

  task automatic test_empty();
    stream[0] = 8'h00;
    stream[1] = 8'h00;
    clear_log();
    pulse_start();
    send_stream(2, 0);
    repeat (2) @(posedge clk); #1;
    checks++;
    if (wr_addr.size() != 0) begin
      failures++;
      $display("FAIL empty_no_write got=%0d exp=0", wr_addr.size());
    end
    checks++;
    if ({done, error, cpu_hold, byte_ready, words_written} !== {4'b1000, 8'd0}) begin
      failures++;
      $display("FAIL empty_final got=%b/%0d exp=1000/0", {done, error, cpu_hold, byte_ready},
               words_written);
    end
  endtask

  task automatic test_reset_mid_load();
    set_normal(8'h0B);
    clear_log();
    pulse_start();
    send_stream(6, 0);
    rst = 1'b1;
    #1;
    checks++;
    if ({cpu_hold, byte_ready, mem_we, done, error} !== 5'b10000) begin
      failures++;
      $display("FAIL midrst_flags got=%b exp=10000", {cpu_hold, byte_ready, mem_we, done, error});
    end
    checks++;
    if ({words_written, mem_wa, mem_wd} !== 48'h0) begin
      failures++;
      $display("FAIL midrst_regs got=%h exp=0", {words_written, mem_wa, mem_wd});
    end
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    grab_writes();
    checks++;
    if (wr_addr.size() != 1 || got0 !== c_EXP_W0) begin
      failures++;
      $display("FAIL midrst_written n=%0d w0=%h exp=1 %h", wr_addr.size(), got0, c_EXP_W0);
    end
    clear_log();
    @(posedge clk); #1;
    pulse_start();
    send_stream(10, 0);
    repeat (2) @(posedge clk); #1;
    grab_writes();
    checks++;
    if (wr_addr.size() != 2 || got0 !== c_EXP_W0 || got1 !== c_EXP_W1 ||
        {done, error, cpu_hold} !== 3'b100) begin
      failures++;
      $display("FAIL midrst_reload n=%0d got=%h,%h flags=%b exp=2 %h,%h 100", wr_addr.size(),
               got0, got1, {done, error, cpu_hold}, c_EXP_W0, c_EXP_W1);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stalled();
    test_bad_checksum();
    test_empty();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
